// File: rtl/cla_result_serializer_if.sv
// Handshake and serial-line bundle between a CLA result source and the serializer.
interface cla_result_serializer_if #(
    parameter int SUM_W = 4
);
    logic             i_load;
    logic [SUM_W-1:0] i_sum;
    logic             i_cout;
    logic             o_ready;
    logic             o_busy;
    logic             o_out;
    logic             o_done;

    modport master (
        output i_load, i_sum, i_cout,
        input  o_ready, o_busy, o_out, o_done
    );

    modport slave (
        input  i_load, i_sum, i_cout,
        output o_ready, o_busy, o_out, o_done
    );
endinterface

// File: rtl/cla_result_serializer.sv
// Frames one CLA result ({cout,sum}) as start / data LSB-first / optional even parity / stop
// on a single registered, idle-high serial line.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | line high, ready for a load
// S_START  | start bit (0) on the line
// S_DATA   | shifting {cout,sum} out LSB-first
// S_PARITY | even-parity bit over the data bits
// S_STOP   | stop bit (1); done pulses on the following idle cycle
module cla_result_serializer #(
    parameter int SUM_W        = 4,
    parameter int CLKS_PER_BIT = 2,
    parameter int PARITY_EN    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    cla_result_serializer_if.slave  bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(SUM_W + 1);
    localparam logic [CW-1:0] TICK_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(SUM_W);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_tick;
    logic [BW-1:0]    r_bit_cnt;
    logic [SUM_W:0]   r_shreg;
    logic             r_parity;
    logic             r_out;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [CW-1:0]    w_tick_nxt;
    logic [BW-1:0]    w_bit_cnt_nxt;
    logic [SUM_W:0]   w_shreg_nxt;
    logic             w_parity_nxt;
    logic             w_out_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_tick_tc;
    logic             w_accept;
    logic [SUM_W:0]   w_frame_in;

    assign w_tick_tc  = (r_tick == '0);
    assign w_accept   = bus.i_load && !r_busy;
    assign w_frame_in = {bus.i_cout, bus.i_sum};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_tick    <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_parity  <= 1'b0;
            r_out     <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tick    <= w_tick_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shreg   <= w_shreg_nxt;
            r_parity  <= w_parity_nxt;
            r_out     <= w_out_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Bit period is a down-counter reloaded on each terminal count.
    always_comb begin
        w_state_nxt   = r_state;
        w_tick_nxt    = r_tick;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shreg_nxt   = r_shreg;
        w_parity_nxt  = r_parity;
        if (r_state != S_IDLE) begin
            w_tick_nxt = w_tick_tc ? TICK_RELOAD : (r_tick - CW'(1));
        end
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = S_START;
                    w_shreg_nxt   = w_frame_in;
                    w_parity_nxt  = ^w_frame_in;
                    w_tick_nxt    = TICK_RELOAD;
                    w_bit_cnt_nxt = '0;
                end
            end
            S_START: begin
                if (w_tick_tc) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_tick_tc) begin
                    w_shreg_nxt = r_shreg >> 1;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_tick_tc) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_tick_tc) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the line itself is a flop.
    always_comb begin
        w_out_nxt  = 1'b1;
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (r_state == S_STOP) && (w_state_nxt == S_IDLE);
        case (w_state_nxt)
            S_START:  w_out_nxt = 1'b0;
            S_DATA:   w_out_nxt = w_shreg_nxt[0];
            S_PARITY: w_out_nxt = w_parity_nxt;
            default:  w_out_nxt = 1'b1;
        endcase
    end

    assign bus.o_out   = r_out;
    assign bus.o_busy  = r_busy;
    assign bus.o_ready = ~r_busy;
    assign bus.o_done  = r_done;
endmodule

// File: tb/tb_cla_result_serializer.sv
// Directed bench: default build (2 clks/bit, parity) and a 1 clk/bit, no-parity build.
module tb_cla_result_serializer;
    logic clk;
    logic rst0;
    logic rst1;
    int   n_checks;
    int   n_errors;

    cla_result_serializer_if #(.SUM_W(4)) b0 ();
    cla_result_serializer_if #(.SUM_W(4)) b1 ();

    cla_result_serializer #(.SUM_W(4), .CLKS_PER_BIT(2), .PARITY_EN(1)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (b0)
    );

    cla_result_serializer #(.SUM_W(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // exp_bits[7] is the first (start) bit on the line. Called just after a negedge.
    task automatic frame0(input logic [7:0] exp_bits, input logic [3:0] s, input logic c,
                          input bit hold_load, input bit busy_load);
        b0.i_load = 1'b1;
        b0.i_sum  = s;
        b0.i_cout = c;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (!hold_load) begin
                b0.i_load = 1'b0;
                b0.i_sum  = ~s;
                b0.i_cout = ~c;
            end
            if (busy_load && k == 5) begin
                b0.i_load = 1'b1;
                b0.i_sum  = 4'hF;
                b0.i_cout = 1'b1;
            end
            if (busy_load && k == 6) b0.i_load = 1'b0;
            chk("f0_out",   {31'd0, b0.o_out},   {31'd0, exp_bits[7 - (k - 1) / 2]});
            chk("f0_busy",  {31'd0, b0.o_busy},  32'd1);
            chk("f0_ready", {31'd0, b0.o_ready}, 32'd0);
            chk("f0_done",  {31'd0, b0.o_done},  32'd0);
        end
        @(negedge clk);
        chk("f0_done_pulse", {31'd0, b0.o_done},  32'd1);
        chk("f0_idle_out",   {31'd0, b0.o_out},   32'd1);
        chk("f0_idle_ready", {31'd0, b0.o_ready}, 32'd1);
        chk("f0_idle_busy",  {31'd0, b0.o_busy},  32'd0);
    endtask

    // exp_bits[6] is the start bit.
    task automatic frame1(input logic [6:0] exp_bits, input logic [3:0] s, input logic c);
        b1.i_load = 1'b1;
        b1.i_sum  = s;
        b1.i_cout = c;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            b1.i_load = 1'b0;
            b1.i_sum  = ~s;
            chk("f1_out",  {31'd0, b1.o_out},  {31'd0, exp_bits[7 - k]});
            chk("f1_busy", {31'd0, b1.o_busy}, 32'd1);
            chk("f1_done", {31'd0, b1.o_done}, 32'd0);
        end
        @(negedge clk);
        chk("f1_done_pulse", {31'd0, b1.o_done},  32'd1);
        chk("f1_idle_out",   {31'd0, b1.o_out},   32'd1);
        chk("f1_idle_ready", {31'd0, b1.o_ready}, 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst0      = 1'b1;
        rst1      = 1'b1;
        b0.i_load = 1'b0;
        b0.i_sum  = 4'h0;
        b0.i_cout = 1'b0;
        b1.i_load = 1'b0;
        b1.i_sum  = 4'h0;
        b1.i_cout = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out0",   {31'd0, b0.o_out},   32'd1);
        chk("rst_ready0", {31'd0, b0.o_ready}, 32'd1);
        chk("rst_busy0",  {31'd0, b0.o_busy},  32'd0);
        chk("rst_done0",  {31'd0, b0.o_done},  32'd0);
        chk("rst_out1",   {31'd0, b1.o_out},   32'd1);
        chk("rst_ready1", {31'd0, b1.o_ready}, 32'd1);
        rst0 = 1'b0;
        rst1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_out0",  {31'd0, b0.o_out},  32'd1);
            chk("idle_done0", {31'd0, b0.o_done}, 32'd0);
            chk("idle_out1",  {31'd0, b1.o_out},  32'd1);
        end

        // 1011 / cout=1: data 1,1,0,1,1 -> four ones, parity 0
        frame0(8'b01101101, 4'b1011, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("post1_done", {31'd0, b0.o_done}, 32'd0);

        // 0001 / cout=0: single one, parity 1
        frame0(8'b01000011, 4'b0001, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("post2_done", {31'd0, b0.o_done}, 32'd0);

        // load of 4'hF mid-frame must be ignored
        frame0(8'b00110001, 4'b0110, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("busyload_done", {31'd0, b0.o_done}, 32'd0);
            chk("busyload_out",  {31'd0, b0.o_out},  32'd1);
            chk("busyload_busy", {31'd0, b0.o_busy}, 32'd0);
        end

        // load held high: frames separated by one idle/done cycle
        frame0(8'b01100001, 4'h3, 1'b0, 1'b1, 1'b0);
        frame0(8'b01100001, 4'h3, 1'b0, 1'b1, 1'b0);
        b0.i_load = 1'b0;
        @(negedge clk);
        chk("b2b_end_busy", {31'd0, b0.o_busy}, 32'd0);
        chk("b2b_end_done", {31'd0, b0.o_done}, 32'd0);

        // reset in the middle of DATA on the 1 clk/bit build
        b1.i_load = 1'b1;
        b1.i_sum  = 4'h5;
        b1.i_cout = 1'b0;
        @(negedge clk);
        b1.i_load = 1'b0;
        chk("mid_start_out", {31'd0, b1.o_out}, 32'd0);
        @(negedge clk);
        chk("mid_data_busy", {31'd0, b1.o_busy}, 32'd1);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        chk("mid_rst_out",   {31'd0, b1.o_out},   32'd1);
        chk("mid_rst_ready", {31'd0, b1.o_ready}, 32'd1);
        chk("mid_rst_done",  {31'd0, b1.o_done},  32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mid_after_out",  {31'd0, b1.o_out},  32'd1);
            chk("mid_after_done", {31'd0, b1.o_done}, 32'd0);
        end

        // 1010 / cout=1 with no parity: 0,0,1,0,1,1,1
        frame1(7'b0010111, 4'hA, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
